// File: rtl/mix_pipe_pkg.sv
// Shared types and the per-stage transform for the mix_pipe datapath.
// Pure definitions; no state, no latency.
package mix_pipe_pkg;

  typedef enum logic [1:0] {
    MIX  = 2'd0,
    ADD  = 2'd1,
    XOR  = 2'd2,
    PASS = 2'd3
  } mode_e;

  // Widest datapath supported; callers truncate the result to their WIDTH,
  // which keeps the arithmetic modulo 2^WIDTH.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] mix_op(input logic [MAX_W-1:0] x,
                                              input mode_e            mode,
                                              input logic [MAX_W-1:0] idx,
                                              input logic [MAX_W-1:0] k);
    logic [MAX_W-1:0] r;
    case (mode)
      MIX:     r = (x + k) ^ idx;
      ADD:     r = x + k;
      XOR:     r = x ^ idx;
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mix_pipe_stage.sv
// One register stage: holds valid/data/mode, loads the transformed upstream beat on adv.
// Latency 1 cycle; stalls (holds) when adv is low, flush clears only the valid bit.
module mix_pipe_stage
  import mix_pipe_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               IDX   = 0,
  parameter logic [MAX_W-1:0] ADD_K = 64'h0000_0000_DEAD_BEEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_dat,
  input  logic [1:0]       prev_mode,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic [1:0]       mode
);

  logic [WIDTH-1:0] nxt;

  // The head stage captures the producer beat untransformed.
  always_comb begin
    nxt = prev_dat;
    if (IDX != 0)
      nxt = WIDTH'(mix_op(MAX_W'(prev_dat), mode_e'(prev_mode), MAX_W'(IDX), ADD_K));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      dat  <= '0;
      mode <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (adv) begin
      vld <= prev_vld;
      if (prev_vld) begin
        dat  <= nxt;
        mode <= prev_mode;
      end
    end
  end

endmodule

// File: rtl/mix_pipe.sv
// Elastic STAGES-deep add/xor mixing pipeline with valid/ready and occupancy count.
// Latency STAGES-1 cycles; bubbles collapse under backpressure, in_ready follows out_ready combinationally.
module mix_pipe
  import mix_pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               STAGES = 16,
  parameter logic [MAX_W-1:0] ADD_K  = 64'h0000_0000_DEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [1:0]                   in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OW = $clog2(STAGES + 1);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  d [STAGES];
  logic [1:0]        m [STAGES];
  logic              accept;
  logic              emit;

  // A stage can advance unless it and every stage after it are full with the
  // consumer stalled; evaluated as a running AND to avoid a self-referencing vector.
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    adv       = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full_tail = full_tail & v[i];
      adv[i]    = out_ready | !full_tail;
    end
  end

  assign in_ready  = adv[0] & !flush;
  assign accept    = in_valid & in_ready;
  assign emit      = v[STAGES-1] & out_ready;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             pv;
    logic [WIDTH-1:0] pd;
    logic [1:0]       pm;

    if (i == 0) begin : g_head
      assign pv = accept;
      assign pd = in_data;
      assign pm = in_mode;
    end else begin : g_link
      assign pv = v[i-1];
      assign pd = d[i-1];
      assign pm = m[i-1];
    end

    mix_pipe_stage #(
      .WIDTH (WIDTH),
      .IDX   (i),
      .ADD_K (ADD_K)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .adv       (adv[i]),
      .prev_vld  (pv),
      .prev_dat  (pd),
      .prev_mode (pm),
      .vld       (v[i]),
      .dat       (d[i]),
      .mode      (m[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (accept && !emit) begin
      occupancy <= occupancy + OW'(1);
    end else if (!accept && emit) begin
      occupancy <= occupancy - OW'(1);
    end
  end

endmodule

// File: tb/tb_mix_pipe.sv
// Scoreboard bench for mix_pipe: default 32-bit/16-stage instance plus two 8-bit/3-stage instances.
module tb_mix_pipe;
  import mix_pipe_pkg::*;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  occupancy;

  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic [1:0]  s_mode = '0;
  logic        s_out_ready = 1'b1;
  logic        a_ready, b_ready, a_valid, b_valid;
  logic [7:0]  a_data, b_data;
  logic [1:0]  a_occ, b_occ;

  mix_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  mix_pipe #(.WIDTH(8), .STAGES(3), .ADD_K(64'h10)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(s_valid), .in_ready(a_ready), .in_data(s_data), .in_mode(s_mode),
    .out_valid(a_valid), .out_ready(s_out_ready), .out_data(a_data),
    .occupancy(a_occ)
  );

  mix_pipe #(.WIDTH(8), .STAGES(3), .ADD_K(64'hFF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(s_valid), .in_ready(b_ready), .in_data(s_data), .in_mode(s_mode),
    .out_valid(b_valid), .out_ready(s_out_ready), .out_data(b_data),
    .occupancy(b_occ)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dat;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  exp_t       e_mon;
  int         n_checks = 0;
  int         n_fail = 0;
  int         model_occ = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, i.e. well away from the rising edge.
  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      model_occ = 0;
    end else begin
      #2;
      if (rst_n) begin
        chk("occupancy", 32'(occupancy), 32'(model_occ));
        if (occupancy == 5'(S) && !out_ready) chk("full_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%08h, expected no beat (cycle %0d)", out_data, cyc);
          end else begin
            e_mon = sb.pop_front();
            chk("out_data", out_data, e_mon.dat);
            if (e_mon.lat) chk("latency", 32'(cyc - e_mon.acc), 32'(S - 1));
          end
        end
        if (a_valid) begin
          if (qa.size() == 0) chk("a_unexpected", 32'(a_data), 32'hFFFF_FFFF);
          else chk("a_out_data", 32'(a_data), 32'(qa.pop_front()));
        end
        if (b_valid) begin
          if (qb.size() == 0) chk("b_unexpected", 32'(b_data), 32'hFFFF_FFFF);
          else chk("b_out_data", 32'(b_data), 32'(qb.pop_front()));
        end
        model_occ = flush ? 0 : model_occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      end
    end
  end

  task automatic send(input logic [31:0] dv, input logic [1:0] mv, input logic [31:0] ev, input bit lat);
    int   budget;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = dv;
    in_mode  = mv;
    #1;
    budget = 0;
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    chk("accept", 32'(in_ready), 32'd1);
    if (in_ready) begin
      e.dat = ev;
      e.acc = cyc + 1;
      e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic ssend(input logic [7:0] dv, input logic [1:0] mv, input logic [7:0] ea, input logic [7:0] eb);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = dv;
    s_mode  = mv;
    #1;
    chk("small_in_ready", 32'(a_ready & b_ready), 32'd1);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 100 && (sb.size() + qa.size() + qb.size()) != 0; c++) @(negedge clk);
    chk(nm, 32'(sb.size() + qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    int   k;
    logic [4:0] peak;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 8-bit, 3-stage instances: MIX with K=0x10 and the wrapping K=0xFF
    ssend(8'h00, MIX, 8'h23, 8'hFF);
    ssend(8'h01, MIX, 8'h22, 8'h02);
    @(negedge clk);
    s_valid = 1'b0;
    wait_drain("small_drain");

    // PASS: single beat, latency and occupancy peak
    send(32'h1234_5678, PASS, 32'h1234_5678, 1'b1);
    idle();
    peak = '0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (occupancy > peak) peak = occupancy;
    end
    chk("occ_peak", 32'(peak), 32'd1);

    // XOR and ADD back to back
    send(32'hA5A5_A5A5, XOR, 32'hA5A5_A5A5, 1'b1);
    send(32'h0000_0000, ADD, 32'h0C2E_3001, 1'b1);
    idle();
    wait_drain("xor_add_drain");

    // Backpressure: 20 counting beats against a stalled consumer
    @(negedge clk);
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      in_valid = (k < 20);
      in_data  = 32'(k);
      in_mode  = PASS;
      #1;
      if (in_valid && in_ready) begin
        sb.push_back('{dat: 32'(k), acc: cyc + 1, lat: 1'b0});
        k++;
      end
    end
    chk("bp_accepted", 32'(k), 32'(S));
    chk("bp_occupancy", 32'(occupancy), 32'(S));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_data_stable", out_data, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'(k);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    sb.push_back('{dat: 32'(k), acc: cyc + 1, lat: 1'b0});
    k++;
    while (k < 20) begin
      send(32'(k), PASS, 32'(k), 1'b0);
      k++;
    end
    idle();
    wait_drain("bp_drain");

    // Flush with 10 beats held at the tail
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(32'h100 + 32'(i), PASS, 32'h100 + 32'(i), 1'b0);
    idle();
    repeat (12) @(negedge clk);
    #1;
    chk("preflush_occupancy", 32'(occupancy), 32'd10);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_0BAD;
    flush    = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_out_valid_now", 32'(out_valid), 32'd1);
    sb.delete();
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("postflush_occupancy", 32'(occupancy), 32'd0);
    chk("postflush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(32'hCAFE_F00D, PASS, 32'hCAFE_F00D, 1'b1);
    idle();
    wait_drain("flush_drain");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) send(32'h11 * 32'(i + 1), PASS, 32'h11 * 32'(i + 1), 1'b0);
    idle();
    repeat (4) @(negedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    send(32'h5A5A_5A5A, PASS, 32'h5A5A_5A5A, 1'b1);
    idle();
    wait_drain("rst_drain");
    repeat (20) @(negedge clk);

    chk("final_queue_empty", 32'(sb.size()), 32'd0);
    chk("final_small_occ", 32'({a_occ, b_occ}), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mix_pipe.md
# mix_pipe

Parametrised elastic mixing pipeline. Generalises the fixed 16-stage, 32-bit add/xor mixing core to configurable width, depth and add constant. Adds a per-beat mode, a valid/ready handshake with full backpressure, a synchronous flush and an occupancy count. Sits between a producer and a consumer stream as a deterministic scrambling/stress datapath.

## Interface
- WIDTH, 32, data width in bits; must satisfy WIDTH ≥ $clog2(STAGES).
- STAGES, 16, number of pipeline registers, ≥ 2.
- ADD_K, 32'hDEAD_BEEF, add constant; low WIDTH bits used.
- clk  in  1  the single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all in-flight beats.
- in_valid  in  1  producer beat valid.
- in_ready  out  1  pipeline accepts beat this cycle.
- in_data  in  WIDTH  beat payload.
- in_mode  in  2  per-beat transform: 0 MIX, 1 ADD, 2 XOR, 3 PASS.
- out_valid  out  1  stage STAGES-1 holds a beat.
- out_ready  in  1  consumer accepts beat.
- out_data  out  WIDTH  payload of stage STAGES-1.
- occupancy  out  $clog2(STAGES+1)  number of valid stages.

## Operation
- Each stage i holds v[i], d[i] and m[i]. Stage 0 captures in_data/in_mode raw, with no transform.
- Stage i≥1 loads f(d[i-1], m[i-1], i); m travels unchanged.
  - MIX: (x + K) ^ i.
  - ADD: x + K.
  - XOR: x ^ i.
  - PASS: x.
- Arithmetic is modulo 2^WIDTH. The index i is zero-extended to WIDTH.
- Advance chain (combinational):
  - adv[STAGES-1] = !v[STAGES-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1].
- in_ready = adv[0] & !flush.
- On a clock edge with adv[i]:
  - v[i] ← v[i-1] (stage 0: in_valid & in_ready).
  - d[i]/m[i] load only when the incoming valid is 1; otherwise they hold.
- Bubbles collapse: a stall at the output compresses gaps and never drops or duplicates beats.
- out_data holds the last emitted value while out_valid=0.
- flush has priority over everything:
  - Next edge clears all v[i] and sets occupancy to 0. d/m are unchanged.
  - No beat is accepted that cycle.
  - out_valid still reflects the current state that cycle; a same-cycle out_valid&out_ready transfer counts as delivered.
- occupancy is a registered counter:
  - +1 on accept, -1 on emit.
  - Unchanged on simultaneous accept+emit.
  - 0 on flush.
  - Must always equal popcount(v).
- Reset (async assert, sync deassertion by system):
  - All v, d, m and occupancy go to 0.
  - Therefore out_valid=0, out_data=0, occupancy=0, and in_ready=1 (when flush=0).

## Timing
- Beat accepted at edge E appears at out_valid/out_data after edge E+STAGES-1, provided there are no stalls.
- Throughput is 1 beat/cycle with out_ready held high.
- in_ready depends combinationally on out_ready through the adv chain, by design. The consumer must not make out_ready depend on in_ready.
- Full pipeline with out_ready=0: in_ready=0. Beats hold in place, out_data is stable and out_valid stays 1.
- out_ready rising while full: in_ready=1 in the same cycle, and one beat enters as one leaves.
- Reset asserted mid-stream: all beats are lost immediately. No output transfer is valid until the next accepted beat completes its latency.

## Structure
- Package mix_pipe_pkg holds:
  - mode_e enum (MIX=0, ADD=1, XOR=2, PASS=3).
  - mix_op function (x, mode, idx, k, width-generic through the parameter).
- Sub-module mix_pipe_stage covers one register stage: v/d/m, load enable and mix_op.
- Top mix_pipe generates STAGES instances, plus the adv chain and the occupancy counter.

## Test plan
- Defaults, PASS, in_data=0x1234_5678, out_ready=1 → out_data=0x1234_5678 with out_valid high exactly STAGES-1 edges after acceptance; occupancy peaks at 1.
- Defaults, XOR, in_data=0xA5A5_A5A5 → 0xA5A5_A5A5 (xor of 1..15 is 0). ADD, in_data=0 → 0x0C2E_3001.
- WIDTH=8, STAGES=3, ADD_K=8'h10:
  - MIX 0x00 → 0x23.
  - With ADD_K=8'hFF, MIX 0x01 → 0x02 (wrap-around).
- Backpressure:
  - Stream 20 beats with counting data, out_ready=0 for 25 cycles → in_ready=0 once occupancy=STAGES.
  - Release → all 20 beats emitted in order with no loss or duplication. occupancy==popcount(v) every cycle.
- flush with pipeline holding 10 beats and in_valid=1 → in_ready=0 that cycle, occupancy=0 and out_valid=0 the next cycle. The next beat emerges with normal latency.
- rst_n low mid-stream for 1 cycle (asynchronous, between edges) → out_valid=0, out_data=0, occupancy=0 immediately. No stale beats appear afterwards.
